// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for mem_port_arbiter: FSM state encoding,
// requester IDs, memory-latency bound and latency-counter type.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    ACK
  } state_e;

  // Requester IDs; also the encoding of the round-robin last-granted pointer.
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port (IReq/IAddr/IRdata/IAck), the data port
// (DReq/DWe/DAddr/DWdata/DRdata/DAck), the memory command port
// (MAddr/MWdata/MRead/MWrite/MRdata) and the Busy flag.
//   slave  : the arbiter side (consumes requests, drives memory commands)
//   master : the core + memory side
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IRdata;
  logic              IAck;

  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWdata;
  logic [DATA_W-1:0] DRdata;
  logic              DAck;

  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MWdata;
  logic              MRead;
  logic              MWrite;
  logic [DATA_W-1:0] MRdata;

  logic              Busy;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWdata, MRdata,
    output IRdata, IAck, DRdata, DAck, MAddr, MWdata, MRead, MWrite, Busy
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWdata, MRdata,
    input  IRdata, IAck, DRdata, DAck, MAddr, MWdata, MRead, MWrite, Busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between fetch and data requests.
//   ireq_i  : fetch request
//   dreq_i  : data request
//   last_i  : requester granted last (REQ_FETCH / REQ_DATA)
//   grant_o : winning requester ID (only meaningful when a request is present)
// Build option: MEM_ARB_RR_EN selects round-robin on ties; otherwise data has
// fixed priority and last_i is ignored.
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic ireq_i,
  input  logic dreq_i,
  input  logic last_i,
  output logic grant_o
);

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that was not granted last wins.
  assign grant_o = (ireq_i && dreq_i) ? ~last_i
                 : (dreq_i ? REQ_DATA : REQ_FETCH);
`else
  logic unused_last;
  assign unused_last = last_i;
  assign grant_o     = dreq_i ? REQ_DATA : REQ_FETCH;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported word memory between instruction fetch and data
// access. One command at a time: IDLE -> CMD -> (WAIT x MEM_LAT) -> ACK for
// reads, IDLE -> CMD -> ACK for writes; IDLE is visited between transactions.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : mem_port_arbiter_if.slave (fetch, data, memory ports and Busy)
// Parameters: ADDR_W, DATA_W, MEM_LAT (read latency, legal 1..MEM_LAT_MAX).
// Build option: MEM_ARB_RR_EN enables round-robin tie breaking; by default
// data has fixed priority over fetch.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               Clk,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);

  state_e            state_q;
  cnt_t              cnt_q;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] mwdata_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;
  logic              mread_q;
  logic              mwrite_q;
  logic              iack_q;
  logic              dack_q;
  logic              busy_q;
  logic              last_d;
  logic              grant_d;

`ifdef MEM_ARB_RR_EN
  logic last_q;
  assign last_d = last_q;
`else
  assign last_d = REQ_FETCH;
`endif

  mem_arb_pick u_pick (
    .ireq_i  (bus.IReq),
    .dreq_i  (bus.DReq),
    .last_i  (last_d),
    .grant_o (grant_d)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= REQ_FETCH;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      mread_q  <= 1'b0;
      mwrite_q <= 1'b0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q   <= REQ_FETCH;
`endif
    end else begin
      // NOTE: strobes default low each cycle and are raised only on the
      // transition into the state that owns them, giving one-cycle pulses.
      mread_q  <= 1'b0;
      mwrite_q <= 1'b0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.IReq || bus.DReq) begin
            win_q   <= grant_d;
            busy_q  <= 1'b1;
            state_q <= CMD;
`ifdef MEM_ARB_RR_EN
            last_q  <= grant_d;
`endif
            if (grant_d == REQ_DATA) begin
              maddr_q  <= bus.DAddr;
              mwdata_q <= bus.DWdata;
              we_q     <= bus.DWe;
              mread_q  <= ~bus.DWe;
              mwrite_q <= bus.DWe;
            end else begin
              maddr_q  <= bus.IAddr;
              we_q     <= 1'b0;
              mread_q  <= 1'b1;
            end
          end
        end

        CMD: begin
          if (we_q) begin
            dack_q  <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q   <= cnt_t'(MEM_LAT);
            state_q <= WAIT;
          end
        end

        WAIT: begin
          cnt_q <= cnt_q - cnt_t'(1);
          // Count 1 marks the cycle in which MRdata is valid.
          if (cnt_q == cnt_t'(1)) begin
            state_q <= ACK;
            if (win_q == REQ_DATA) begin
              drdata_q <= bus.MRdata;
              dack_q   <= 1'b1;
            end else begin
              irdata_q <= bus.MRdata;
              iack_q   <= 1'b1;
            end
          end
        end

        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MAddr  = maddr_q;
  assign bus.MWdata = mwdata_q;
  assign bus.MRead  = mread_q;
  assign bus.MWrite = mwrite_q;
  assign bus.IRdata = irdata_q;
  assign bus.IAck   = iack_q;
  assign bus.DRdata = drdata_q;
  assign bus.DAck   = dack_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiters share one stimulus: dut0 (MEM_LAT=2) is the main device;
// dut1 (MEM_LAT=1) and dut2 (MEM_LAT=7) are held in reset until the latency
// sweep. Each has its own latency-accurate memory model. Expected behaviour
// comes from a transaction-level schedule built from the arbitration and
// latency rules. Build option: MEM_ARB_RR_EN (round-robin expectations).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam int LAT2 = 7;
  localparam int MAXG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst_sw;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if bus0 ();
  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus2 ();

  assign {bus0.IReq, bus0.IAddr, bus0.DReq, bus0.DWe, bus0.DAddr, bus0.DWdata} =
         {ireq, iaddr, dreq, dwe, daddr, dwdata};
  assign {bus1.IReq, bus1.IAddr, bus1.DReq, bus1.DWe, bus1.DAddr, bus1.DWdata} =
         {ireq, iaddr, dreq, dwe, daddr, dwdata};
  assign {bus2.IReq, bus2.IAddr, bus2.DReq, bus2.DWe, bus2.DAddr, bus2.DWdata} =
         {ireq, iaddr, dreq, dwe, daddr, dwdata};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0)) dut0 (
    .Clk(clk), .Reset(rst0), .bus(bus0));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1)) dut1 (
    .Clk(clk), .Reset(rst_sw), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT2)) dut2 (
    .Clk(clk), .Reset(rst_sw), .bus(bus2));

  // Memory command ports flattened so one generate loop can model all three.
  logic        mread [3];
  logic        mwrite[3];
  logic [31:0] maddr [3];
  logic [31:0] mwdata[3];
  logic [31:0] mrdata[3];

  assign {mread[0], mwrite[0], maddr[0], mwdata[0]} = {bus0.MRead, bus0.MWrite, bus0.MAddr, bus0.MWdata};
  assign {mread[1], mwrite[1], maddr[1], mwdata[1]} = {bus1.MRead, bus1.MWrite, bus1.MAddr, bus1.MWdata};
  assign {mread[2], mwrite[2], maddr[2], mwdata[2]} = {bus2.MRead, bus2.MWrite, bus2.MAddr, bus2.MWdata};
  assign bus0.MRdata = mrdata[0];
  assign bus1.MRdata = mrdata[1];
  assign bus2.MRdata = mrdata[2];

  function automatic logic [31:0] init_word(int i);
    return (i == 1) ? 32'h8C22_0004 : (32'hA500_0000 ^ (i * 32'h0101_0137));
  endfunction

  // Word memory: read data is valid only in the cycle MEM_LAT after MRead.
  for (genvar g = 0; g < 3; g++) begin : g_mem
    localparam int LAT = (g == 0) ? LAT0 : (g == 1) ? LAT1 : LAT2;
    logic [31:0] mem [64];
    logic [5:0]  rd_idx = '0;
    int          dly    = 0;
    initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    always @(posedge clk) begin
      if (mwrite[g]) mem[maddr[g][7:2]] <= mwdata[g];
      if (mread[g]) begin
        rd_idx <= maddr[g][7:2];
        dly    <= 1;
      end else if (dly != 0 && dly < LAT) dly <= dly + 1;
      else dly <= 0;
    end
    assign mrdata[g] = (dly == LAT) ? mem[rd_idx] : 32'hBAD0_0BAD;
  end

  // Reference state for dut0.
  logic [31:0] ref_mem [64];
  logic [31:0] exp_irdata, exp_drdata;
  bit          last_data;   // 1 = data was granted last

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_data  = 1'b0;
    exp_irdata = '0;
    exp_drdata = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " IAck"},   bus0.IAck,   0);
    check({tag, " DAck"},   bus0.DAck,   0);
    check({tag, " IRdata"}, bus0.IRdata, 0);
    check({tag, " DRdata"}, bus0.DRdata, 0);
    check({tag, " MAddr"},  bus0.MAddr,  0);
    check({tag, " MWdata"}, bus0.MWdata, 0);
    check({tag, " MRead"},  bus0.MRead,  0);
    check({tag, " MWrite"}, bus0.MWrite, 0);
    check({tag, " Busy"},   bus0.Busy,   0);
  endtask

  // Winner of the next grant: 1 = data.
  function automatic bit pick(bit pi, bit pd);
    if (pi && pd) begin
`ifdef MEM_ARB_RR_EN
      return !last_data;
`else
      return 1'b1;
`endif
    end
    return pd;
  endfunction

  // Drive one request pattern from an IDLE cycle and check dut0 cycle by
  // cycle. Requests are held for the first n_hold grants (each re-grant is a
  // new request); from then on a requester drops its request at its Ack.
  task automatic run(input string tag, input bit ir, input bit dr, input bit we,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] wd, input int n_hold);
    int          g_cmd [MAXG], g_ack [MAXG];
    bit          g_data[MAXG], g_we [MAXG], g_fin[MAXG];
    logic [31:0] g_addr[MAXG], g_rd [MAXG];
    bit          pi, pd, w;
    int          ng, s;
    logic [5:0]  idx;

    pi = ir; pd = dr; ng = 0; s = 0;
    while ((pi || pd) && ng < MAXG) begin
      w         = pick(pi, pd);
      last_data = w;
      g_data[ng] = w;
      g_we[ng]   = w && we;
      g_addr[ng] = w ? da : ia;
      g_cmd[ng]  = s + 1;
      g_ack[ng]  = s + 2 + (g_we[ng] ? 0 : LAT0);
      s          = g_ack[ng] + 1;
      g_fin[ng]  = (ng >= n_hold - 1);
      if (g_fin[ng]) begin
        if (w) pd = 1'b0;
        else   pi = 1'b0;
      end
      idx = g_addr[ng][7:2];
      if (g_we[ng]) ref_mem[idx] = wd;
      g_rd[ng] = ref_mem[idx];
      ng++;
    end

    ireq = ir; dreq = dr; dwe = we; iaddr = ia; daddr = da; dwdata = wd;

    for (int k = 1; k <= s; k++) begin
      bit e_busy, e_mr, e_mw, e_ia, e_da;
      int cj, aj;
      @(posedge clk); #1;
      e_busy = 0; e_mr = 0; e_mw = 0; e_ia = 0; e_da = 0; cj = -1; aj = -1;
      for (int j = 0; j < ng; j++) begin
        if (k >= g_cmd[j] && k <= g_ack[j]) e_busy = 1;
        if (k == g_cmd[j]) begin e_mr = !g_we[j]; e_mw = g_we[j]; cj = j; end
        if (k == g_ack[j]) begin
          if (g_data[j]) e_da = 1; else e_ia = 1;
          aj = j;
        end
      end
      if (aj >= 0 && !g_we[aj]) begin
        if (g_data[aj]) exp_drdata = g_rd[aj];
        else            exp_irdata = g_rd[aj];
      end
      check({tag, " Busy"},   bus0.Busy,   e_busy);
      check({tag, " MRead"},  bus0.MRead,  e_mr);
      check({tag, " MWrite"}, bus0.MWrite, e_mw);
      check({tag, " IAck"},   bus0.IAck,   e_ia);
      check({tag, " DAck"},   bus0.DAck,   e_da);
      check({tag, " IRdata"}, bus0.IRdata, exp_irdata);
      check({tag, " DRdata"}, bus0.DRdata, exp_drdata);
      if (cj >= 0) begin
        check({tag, " MAddr"}, bus0.MAddr, g_addr[cj]);
        if (g_we[cj]) check({tag, " MWdata"}, bus0.MWdata, wd);
      end
      if (aj >= 0 && g_fin[aj]) begin
        if (g_data[aj]) dreq = 1'b0;
        else            ireq = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst0 = 1'b1; rst_sw = 1'b1;
    ireq = 0; dreq = 0; dwe = 0; iaddr = '0; daddr = '0; dwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst0 = 1'b0;

    // Fetch read alone, then data write and read-back.
    run("fetch_rd", 1, 0, 0, 32'h4, 32'h0, 32'h0, 1);
    run("data_wr",  0, 1, 1, 32'h0, 32'h10, 32'hDEAD_BEEF, 1);
    run("data_rd",  0, 1, 0, 32'h0, 32'h10, 32'h0, 1);

    // Fresh pointer, both requests held for four grants.
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    model_reset();
    check_zero("reset2");
    run("tie_hold", 1, 1, 0, 32'h4, 32'h10, 32'h0, 4);

    // Reset during the first WAIT cycle abandons the read.
    ireq = 1'b1; iaddr = 32'h8;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait Busy before", bus0.Busy, 1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_zero("rst_wait");
    ireq = 1'b0; rst0 = 1'b0;
    @(posedge clk); #1;
    check("rst_wait IAck after", bus0.IAck, 0);
    check("rst_wait Busy after", bus0.Busy, 0);
    run("reissue", 1, 0, 0, 32'h8, 32'h0, 32'h0, 1);

    // Randomized request mixes; addresses carry arbitrary high and low bits.
    for (int n = 0; n < 30; n++) begin
      bit ir, dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      run("random", ir, dr, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
          $urandom(), $urandom_range(1, 3));
    end

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=7 instances.
    @(posedge clk); #1;
    rst0 = 1'b1; rst_sw = 1'b1; ireq = 0; dreq = 0;
    @(posedge clk); #1;
    rst0 = 1'b0; rst_sw = 1'b0;
    model_reset();
    ireq = 1'b1; iaddr = 32'h4;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k <= 4) begin
        check("lat1 IAck", bus1.IAck, (k == LAT1 + 2));
        check("lat1 Busy", bus1.Busy, (k >= 1 && k <= LAT1 + 2));
        if (k == LAT1 + 2) check("lat1 IRdata", bus1.IRdata, init_word(1));
      end
      check("lat7 IAck",  bus2.IAck,  (k == LAT2 + 2));
      check("lat7 Busy",  bus2.Busy,  (k >= 1 && k <= LAT2 + 2));
      check("lat7 MRead", bus2.MRead, (k == 1));
      if (k == LAT2 + 2) check("lat7 IRdata", bus2.IRdata, init_word(1));
    end
    ireq = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multi-cycle arbiter that shares one single-ported word memory between the instruction-fetch path and the data-access path of the CPU. It accepts word-level read requests from fetch and read/write requests from the load/store stage. It issues exactly one memory command at a time and returns read data together with a one-cycle acknowledge. It sits between the core (Pc / ALU address) and the unified memory array.

## Interface
- ADDR_W, 32, byte-address width on all ports.
- DATA_W, 32, data word width.
- MEM_LAT, 2, memory read latency in cycles from the command cycle to valid MRdata; legal range 1..7.

- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IReq  in  1  fetch request; held high until IAck.
- IAddr  in  ADDR_W  fetch byte address; stable while IReq is high.
- IRdata  out  DATA_W  fetched word; registered.
- IAck  out  1  one-cycle pulse: fetch complete, IRdata valid.
- DReq  in  1  data request; held high until DAck.
- DWe  in  1  1 = write, 0 = read; stable while DReq is high.
- DAddr  in  ADDR_W  data byte address.
- DWdata  in  DATA_W  write data.
- DRdata  out  DATA_W  read word; registered.
- DAck  out  1  one-cycle pulse: data access complete.
- MAddr  out  ADDR_W  memory byte address; passed unchanged, the memory performs the >>2.
- MWdata  out  DATA_W  memory write data.
- MRead  out  1  memory read strobe, one cycle.
- MWrite  out  1  memory write strobe, one cycle.
- MRdata  in  DATA_W  memory read data.
- Busy  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, CMD, WAIT, ACK.
- **IDLE**
  - If neither IReq nor DReq is high, stay in IDLE.
  - Otherwise, pick a winner (see arbitration), latch its ID, address, write data and write flag, and go to CMD.
- **CMD**
  - Drive MAddr/MWdata from the latched values.
  - Assert MRead for a read, or MWrite for a write, for exactly this cycle.
  - A read loads the counter with MEM_LAT and goes to WAIT; a write goes to ACK.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle where the counter equals 1, capture MRdata into IRdata or DRdata (by winner) and go to ACK.
- **ACK**
  - Assert IAck or DAck (winner only) for one cycle, then go to IDLE.
- **Arbitration**
  - A single requester always wins.
  - On simultaneous IReq and DReq, the winner depends on configuration (see Configuration).
  - The loser's request stays pending and is served in the next IDLE.
- **Data and address rules**
  - IRdata and DRdata hold their last captured values until overwritten.
  - A write never modifies DRdata.
  - The IRdata/DRdata/MAddr/MWdata registers are full DATA_W/ADDR_W wide; no alignment check, and address bits [1:0] are passed through untouched.
- **Requester protocol**
  - A requester may keep Req high after its Ack. That is taken as a new request, with the address and data updated at the Ack edge.
  - Requests that drop before Ack are a protocol violation. After latching, the arbiter ignores input changes.

## Timing
- Reset values: every output is 0 (IAck, DAck, IRdata, DRdata, MAddr, MWdata, MRead, MWrite, Busy). The FSM goes to IDLE, the counter to 0 and the RR pointer to "fetch last".
- Read latency: Req seen in IDLE at cycle t, then:
  - CMD at t+1;
  - MRdata sampled at the end of cycle t+1+MEM_LAT;
  - Ack at t+2+MEM_LAT.
- Write latency: IDLE at t, CMD (MWrite=1) at t+1, Ack at t+2.
- Back-to-back throughput: one read per MEM_LAT+3 cycles, one write per 3 cycles, because IDLE is always visited between transactions.
- Reset asserted in any state takes effect at the next edge:
  - the in-flight command is abandoned;
  - no Ack is issued;
  - strobes drop the cycle after.
- MRead, MWrite, IAck and DAck are never high in the same cycle as each other.

## Configuration
- MEM_ARB_RR_EN
  - **Defined:** round-robin. A one-bit last-granted pointer is updated on every grant. On a tie, the requester not granted last wins. After reset, data wins the first tie.
  - **Undefined:** fixed priority; data always beats fetch. The pointer logic is removed, and fetch can be starved by continuous DReq.

## Structure
- Package mem_arb_pkg:
  - FSM state enum (IDLE, CMD, WAIT, ACK);
  - requester ID constants REQ_FETCH = 0, REQ_DATA = 1;
  - MEM_LAT_MAX = 7;
  - counter width 3.
- One sub-module, mem_arb_pick: combinational winner selection from IReq, DReq and the pointer. Its pointer input is tied off when MEM_ARB_RR_EN is undefined.

## Test plan
- Fetch read alone: reset, memory word 1 = 0x8C220004, IReq=1, IAddr=0x4, MEM_LAT=2 -> MRead one cycle at t+1 with MAddr=0x4; IAck at t+4 with IRdata=0x8C220004.
- Data write then read: DWe=1, DAddr=0x10, DWdata=0xDEADBEEF -> MWrite one cycle, DAck at t+2, DRdata unchanged. Then read 0x10 -> DRdata=0xDEADBEEF.
- Simultaneous requests, IReq and DReq held high for 4 transactions:
  - with MEM_ARB_RR_EN, grant order is D, I, D, I;
  - without it, D, D, D, D and IAck never fires.
- Reset mid-WAIT: Reset high in the first WAIT cycle -> next cycle all outputs 0, no Ack. A request re-issued afterwards completes normally.
- Latency sweep MEM_LAT = 1 and 7: Ack for a read arrives exactly MEM_LAT+2 cycles after the request cycle, and Busy is high exactly from CMD through ACK.
